// File: rtl/instruction_encoder.sv
// Packs a range-checked immediate into an instruction word (inverse of immediate decode)
// and emits it through a valid/ready output register tagged with an IMEM byte address.
module instruction_encoder #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned ERRCNT_W  = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                CLEAR,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [3:0]          IN_SELECT,
  input  logic [31:0]         IN_BASE,
  input  logic [31:0]         IN_IMM,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [31:0]         OUT_INST,
  output logic                OUT_ERR,
  output logic [31:0]         OUT_ADDR,
  output logic [ERRCNT_W-1:0] ERR_COUNT
);

  localparam logic [2:0] FMT_U     = 3'd0;
  localparam logic [2:0] FMT_J     = 3'd1;
  localparam logic [2:0] FMT_I     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_S     = 3'd4;
  localparam logic [2:0] FMT_SHAMT = 3'd5;

  logic                out_valid_q, out_valid_d;
  logic [31:0]         out_inst_q, out_inst_d;
  logic                out_err_q, out_err_d;
  logic [31:0]         out_addr_q, out_addr_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;

  logic [31:0] enc_inst;
  logic        enc_err;
  logic        in_fire;
  logic        out_fire;

  // Bits above top field bit t must be a sign extension of bit t (or zero when unsigned).
  function automatic logic range_err(input logic [31:0] imm, input int unsigned t,
                                     input logic uns);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << t;
    if (uns) range_err = (imm & (mask << 1)) != 32'h0;
    else     range_err = ((imm & mask) != 32'h0) && ((imm & mask) != mask);
  endfunction

  always_comb begin
    enc_inst = IN_BASE;
    enc_err  = 1'b0;
    unique case (IN_SELECT[2:0])
      FMT_U: begin
        enc_inst[31:12] = IN_IMM[31:12];
        enc_err         = |IN_IMM[11:0];
      end
      FMT_J: begin
        enc_inst[31:12] = IN_IMM[20:1];
        enc_err         = IN_IMM[0] | range_err(IN_IMM, 20, IN_SELECT[3]);
      end
      FMT_I: begin
        enc_inst[31:20] = IN_IMM[11:0];
        enc_err         = range_err(IN_IMM, 11, IN_SELECT[3]);
      end
      FMT_B: begin
        enc_inst[31:25] = IN_IMM[12:6];
        enc_inst[11:7]  = IN_IMM[5:1];
        enc_err         = IN_IMM[0] | range_err(IN_IMM, 12, IN_SELECT[3]);
      end
      FMT_S: begin
        enc_inst[31:25] = IN_IMM[11:5];
        enc_inst[11:7]  = IN_IMM[4:0];
        enc_err         = range_err(IN_IMM, 11, IN_SELECT[3]);
      end
      FMT_SHAMT: begin
        enc_inst[29:25] = IN_IMM[4:0];
        enc_err         = |IN_IMM[31:5];
      end
      default: enc_err = 1'b1;
    endcase
  end

  assign IN_READY = !out_valid_q || OUT_READY;
  assign in_fire  = IN_VALID && IN_READY;
  assign out_fire = out_valid_q && OUT_READY;

  // Counters account for the departing word; CLEAR wins over an increment.
  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    out_addr_d  = out_addr_q;
    err_count_d = err_count_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_inst_d  = enc_inst;
      out_err_d   = enc_err;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (CLEAR) begin
      out_addr_d  = ADDR_BASE;
      err_count_d = '0;
    end else if (out_fire) begin
      out_addr_d = out_addr_q + 32'(ADDR_STEP);
      if (out_err_q && (err_count_q != {ERRCNT_W{1'b1}}))
        err_count_d = err_count_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0;
      out_err_q   <= 1'b0;
      out_addr_q  <= ADDR_BASE;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
      out_addr_q  <= out_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_INST  = out_inst_q;
  assign OUT_ERR   = out_err_q;
  assign OUT_ADDR  = out_addr_q;
  assign ERR_COUNT = err_count_q;

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
Inverse of the pipeline's immediate decode stage. It takes a base instruction word and a 32-bit immediate, range-checks the immediate, and packs it into the immediate field layout selected by a 4-bit select code, using the same codes and bit layouts the decode stage uses. Encoded words leave through a valid/ready output register, tagged with a running instruction-memory write address. The block feeds the boot/program loader that writes IMEM, and it provides encode/decode round-trip checking in the verification environment.

Parameters:
ADDR_BASE, 32'h0000_0000, OUT_ADDR value after reset or CLEAR
ADDR_STEP, 4, byte increment of OUT_ADDR per accepted output word
ERRCNT_W, 8, width of the saturating error counter

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
CLEAR  in  1  synchronous clear of OUT_ADDR and ERR_COUNT
IN_VALID  in  1  request valid
IN_READY  out  1  block accepts request this cycle
IN_SELECT  in  4  [2:0] format: 000 U, 001 J, 010 I, 011 B, 100 S, 101 shamt; [3] 1 = unsigned range check
IN_BASE  in  32  instruction word; the selected immediate bits are overwritten, all other bits pass through
IN_IMM  in  32  immediate value to encode
OUT_VALID  out  1  encoded word valid
OUT_READY  in  1  consumer accepts word
OUT_INST  out  32  encoded instruction
OUT_ERR  out  1  immediate was out of range, misaligned, or the select code was illegal
OUT_ADDR  out  32  IMEM byte address for OUT_INST
ERR_COUNT  out  ERRCNT_W  saturating count of errored words accepted downstream

Behaviour:
Interface:
- One clock domain (CLK).
- RESET is asynchronous, active-high.

Reset values:
- OUT_VALID=0, OUT_INST=0, OUT_ERR=0, OUT_ADDR=ADDR_BASE, ERR_COUNT=0.
- A word held in the output register when RESET asserts is discarded and is not counted.

Handshake:
- IN_READY = !OUT_VALID || OUT_READY (combinational).
- Input transfer: IN_VALID && IN_READY. The output register loads on the next rising edge and OUT_VALID=1. Latency is 1 cycle; sustained throughput is 1 word/cycle.
- Output transfer: OUT_VALID && OUT_READY. If no new input arrives in the same cycle, OUT_VALID clears.
- While OUT_VALID=1 and OUT_READY=0, OUT_INST, OUT_ERR and OUT_ADDR are held stable.

Packing (the inverse of the decode stage):
- U: INST[31:12]=IMM[31:12]. Error if IMM[11:0]!=0.
- J: INST[31:12]=IMM[20:1]. Error if IMM[0]=1.
- I: INST[31:20]=IMM[11:0].
- B: {INST[31:25],INST[11:7]}=IMM[12:1]. Error if IMM[0]=1.
- S: {INST[31:25],INST[11:7]}=IMM[11:0].
- shamt: INST[29:25]=IMM[4:0]. Error if IMM[31:5]!=0. SELECT[3] is ignored.
- U also ignores SELECT[3].
- Range check for J/I/B/S, with top field bit t = 20, 11, 12, 11 respectively:
  - signed: error unless IMM[31:t+1] all equal IMM[t];
  - unsigned: error unless IMM[31:t+1]==0.
- Select codes 110 and 111: OUT_INST=IN_BASE unchanged, OUT_ERR=1.
- On any error the word is still emitted, with truncated field bits packed as above.

Counters:
- OUT_ADDR advances by ADDR_STEP on each output transfer. It wraps modulo 2^32 with no flag.
- ERR_COUNT increments on each output transfer with OUT_ERR=1 and saturates at all-ones.
- CLEAR sets OUT_ADDR=ADDR_BASE and ERR_COUNT=0 on the next edge and has priority over a same-cycle increment. CLEAR does not affect OUT_VALID, OUT_INST or OUT_ERR.

Simultaneous events:
- Output transfer and input transfer in the same cycle: the new word replaces the old one, and the counters update for the departing word.
- CLEAR in that same cycle: the counters take their clear values.

Test Plan:
- Reset, then I signed, IMM=32'hFFFF_FFFF, BASE=32'h0000_0013, OUT_READY=1 -> next cycle OUT_INST=32'hFFF0_0013, OUT_ERR=0, OUT_ADDR=ADDR_BASE; after the transfer OUT_ADDR=ADDR_BASE+4.
- B signed, IMM=32'h10, BASE=32'h63 -> OUT_INST=32'h0000_0463. Then IMM=32'h11 -> OUT_ERR=1 and ERR_COUNT=1 after the transfer.
- U, IMM=32'h1234_5000, BASE=32'h37 -> 32'h1234_5037. J signed, IMM=32'h0010_0000 -> OUT_ERR=1. J unsigned, IMM=32'h000F_FFFE -> OUT_ERR=0.
- shamt, IMM=31, BASE=32'h0000_1013 -> 32'h3E00_1013. Then IMM=32 -> OUT_ERR=1. Then SELECT=4'b0110 -> OUT_INST=BASE, OUT_ERR=1.
- Backpressure: stream 4 words with OUT_READY low for 3 cycles mid-stream -> IN_READY=0 while stalled, outputs held stable, no word lost or duplicated, OUT_ADDR steps 0,4,8,12.
- Force ERR_COUNT to 255 and send an errored word -> stays 255. Assert CLEAR with a simultaneous output transfer -> OUT_ADDR=ADDR_BASE, ERR_COUNT=0. Assert RESET while OUT_VALID=1 -> OUT_VALID=0 immediately.
